hdlc_rx_deframer: RTL and testbench

Bit-level HDLC receive front end. Samples the serial line `Rx` once per `Clk` and produces the byte-level stream consumed by the Rx buffer and status logic (`Rx_ValidFrame`, `Rx_NewByte`, `Rx_Data`, `Rx_EoF`). Internally it hunts for flags, detects aborts, removes inserted zeros and assembles bytes LSB-first, with an optional CRC-16 frame check.

---
 rtl/hdlc_rx_deframer_pkg.sv | 25 ++
 rtl/hdlc_rx_deframer_if.sv | 40 ++++
 rtl/hdlc_rx_deframer_fcs.sv | 39 +++
 rtl/hdlc_rx_deframer.sv | 202 ++++++++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_rx_deframer_pkg.sv
// -----------------------------------------------------------------------------
// hdlc_pkg
// Shared definitions for the HDLC receive deframer: FSM state encoding, the
// flag/abort patterns as they appear in the 8-bit receive window (newest bit
// in the MSB), the CRC-16 generator polynomial and a single-bit CRC step.
// -----------------------------------------------------------------------------
package hdlc_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } hdlcState_t;

    localparam logic [7:0]  HDLC_FLAG     = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT    = 8'hFE;
    localparam logic [15:0] HDLC_CRC_POLY = 16'h8005;

    // One bit of a left-shifting CRC-16 (MSB feedback), bits in reception order.
    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? HDLC_CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_rx_deframer_if.sv
// -----------------------------------------------------------------------------
// hdlc_rx_deframer_if
// Serial-line inputs and byte-level outputs of the HDLC receive deframer.
//   Rx, RxEN          : serial bit (idle 1) and receiver enable
//   Rx_FlagDetect     : one-cycle pulse, flag seen
//   Rx_AbortDetect    : one-cycle pulse, abort seen
//   Rx_ValidFrame     : high between opening flag and frame termination
//   Rx_NewByte        : one-cycle pulse, Rx_Data holds a new byte
//   Rx_Data[7:0]      : last assembled byte, first received bit in bit 0
//   Rx_EoF            : one-cycle pulse after Rx_ValidFrame falls
//   Rx_FrameError     : with Rx_EoF, misaligned close or enable loss
//   Rx_FCSerr         : with Rx_EoF, CRC residue non-zero
// Modports: master drives the line (source side), slave is the deframer.
// -----------------------------------------------------------------------------
interface hdlc_rx_deframer_if;

    logic       Rx;
    logic       RxEN;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_ValidFrame;
    logic       Rx_NewByte;
    logic [7:0] Rx_Data;
    logic       Rx_EoF;
    logic       Rx_FrameError;
    logic       Rx_FCSerr;

    modport master (
        output Rx, RxEN,
        input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
               Rx_Data, Rx_EoF, Rx_FrameError, Rx_FCSerr
    );

    modport slave (
        input  Rx, RxEN,
        output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_NewByte,
               Rx_Data, Rx_EoF, Rx_FrameError, Rx_FCSerr
    );

endinterface

// File: rtl/hdlc_rx_deframer_fcs.sv
// -----------------------------------------------------------------------------
// hdlc_rx_fcs
// Bit-serial CRC-16 (x^16+x^15+x^2+1, init 0) over kept data bits. When the
// received FCS bytes are included, a clean frame leaves a zero residue.
// Built only when HDLC_RX_FCS_EN is defined.
//   Clk, Rst    : clock, asynchronous active-low reset
//   clear       : restart the CRC (frame entry)
//   bit_valid   : bit_in is a kept data bit
//   bit_in      : data bit, in order of reception
//   residue_ok  : CRC register is zero
// -----------------------------------------------------------------------------
`ifdef HDLC_RX_FCS_EN
module hdlc_rx_fcs
    import hdlc_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic residue_ok
);

    logic [15:0] crc;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            crc <= 16'h0000;
        end else if (clear) begin
            crc <= 16'h0000;
        end else if (bit_valid) begin
            crc <= crcStep(crc, bit_in);
        end
    end

    assign residue_ok = (crc == 16'h0000);

endmodule
`endif

// File: rtl/hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// hdlc_rx_deframer
// Bit-level HDLC receive front end: flag hunt, abort detection, zero removal
// and LSB-first byte assembly, with an optional CRC-16 frame check.
//   Clk   : clock, rising edge
//   Rst   : asynchronous active-low reset
//   rxIf  : hdlc_rx_deframer_if.slave (Rx/RxEN in, byte stream and status out)
// Build option: define HDLC_RX_FCS_EN to include the CRC-16 checker;
// otherwise Rx_FCSerr is tied 0.
// -----------------------------------------------------------------------------
module hdlc_rx_deframer
    import hdlc_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    hdlc_rx_deframer_if.slave rxIf
);

    logic [7:0] sr;
    logic [7:0] srVld;      // window bits still eligible for byte assembly
    logic       flagHit_p0;
    logic       abortHit_p0;
    logic       dBit_p0;
    logic       vld_p0;
    logic       stuffed_p0;
    logic       keep_p0;

    logic       flagDet;
    logic       abortDet;
    hdlcState_t state;
    logic       validFrame;
    logic       closePend;
    logic       errPend;
    logic       eof;
    logic       frameErr;

    logic [2:0] onesCnt;
    logic [2:0] bitCnt;
    logic [7:0] byteCnt;
    logic [7:0] shReg;
    logic [7:0] dataOut;
    logic       newByte;

    logic       openFrame;
    logic       closeFlag;
    logic       closeAbort;
    logic       enLoss;

    // ---- stage p0: window match and departing bit ----
    assign flagHit_p0  = (sr == HDLC_FLAG);
    assign abortHit_p0 = (sr == HDLC_ABORT);
    assign dBit_p0     = sr[0];
    // A match invalidates every bit in the window, including the one leaving now.
    assign vld_p0      = rxIf.RxEN & srVld[0] & ~flagHit_p0 & ~abortHit_p0;
    assign stuffed_p0  = (onesCnt == 3'd5) & ~dBit_p0;
    assign keep_p0     = vld_p0 & (state == FRAME) & ~stuffed_p0;

    assign openFrame  = rxIf.RxEN & (state == HUNT) & flagDet;
    assign closeFlag  = rxIf.RxEN & (state == FRAME) & flagDet &
                        ((byteCnt != 8'd0) || (bitCnt != 3'd0));
    assign closeAbort = rxIf.RxEN & (state == FRAME) & abortDet;
    assign enLoss     = ~rxIf.RxEN & (state == FRAME);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sr       <= 8'hFF;
            srVld    <= 8'h00;
            flagDet  <= 1'b0;
            abortDet <= 1'b0;
        end else begin
            flagDet  <= rxIf.RxEN & flagHit_p0;
            abortDet <= rxIf.RxEN & abortHit_p0;
            if (rxIf.RxEN) begin
                sr    <= {rxIf.Rx, sr[7:1]};
                srVld <= (flagHit_p0 | abortHit_p0) ? 8'h80 : {1'b1, srVld[7:1]};
            end
        end
    end

    // ---- stage p1: zero removal and byte assembly ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            onesCnt <= 3'd0;
            bitCnt  <= 3'd0;
            byteCnt <= 8'd0;
            shReg   <= 8'h00;
            dataOut <= 8'h00;
            newByte <= 1'b0;
        end else begin
            newByte <= 1'b0;
            if (openFrame) begin
                onesCnt <= 3'd0;
                bitCnt  <= 3'd0;
                byteCnt <= 8'd0;
                shReg   <= 8'h00;
            end else if (vld_p0 && (state == FRAME)) begin
                if (stuffed_p0) begin
                    onesCnt <= 3'd0;
                end else begin
                    onesCnt <= dBit_p0 ? ((onesCnt == 3'd7) ? 3'd7 : onesCnt + 3'd1) : 3'd0;
                    shReg   <= {dBit_p0, shReg[7:1]};
                    bitCnt  <= bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        dataOut <= {dBit_p0, shReg[7:1]};
                        newByte <= 1'b1;
                        if (byteCnt != 8'd255) begin
                            byteCnt <= byteCnt + 8'd1;
                        end
                    end
                end
            end
        end
    end

    // ---- stage p2: frame FSM and end-of-frame status ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= HUNT;
            validFrame <= 1'b0;
            closePend  <= 1'b0;
            errPend    <= 1'b0;
            eof        <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            eof       <= closePend;
            frameErr  <= errPend;
            closePend <= 1'b0;
            errPend   <= 1'b0;
            if (!rxIf.RxEN) begin
                state      <= HUNT;
                validFrame <= 1'b0;
                if (enLoss) begin
                    closePend <= 1'b1;
                    errPend   <= 1'b1;
                end
            end else begin
                case (state)
                    HUNT: begin
                        if (openFrame) begin
                            state      <= FRAME;
                            validFrame <= 1'b1;
                        end
                    end
                    FRAME: begin
                        if (closeAbort) begin
                            state      <= HUNT;
                            validFrame <= 1'b0;
                            closePend  <= 1'b1;
                        end else if (closeFlag) begin
                            state      <= HUNT;
                            validFrame <= 1'b0;
                            closePend  <= 1'b1;
                            errPend    <= (bitCnt != 3'd0);
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        validFrame <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rxIf.Rx_FlagDetect  = flagDet;
    assign rxIf.Rx_AbortDetect = abortDet;
    assign rxIf.Rx_ValidFrame  = validFrame;
    assign rxIf.Rx_NewByte     = newByte;
    assign rxIf.Rx_Data        = dataOut;
    assign rxIf.Rx_EoF         = eof;
    assign rxIf.Rx_FrameError  = frameErr;

`ifdef HDLC_RX_FCS_EN
    logic residueOk;
    logic fcsPend;
    logic fcsErr;

    hdlc_rx_fcs u_fcs (
        .Clk        (Clk),
        .Rst        (Rst),
        .clear      (openFrame),
        .bit_valid  (keep_p0),
        .bit_in     (dBit_p0),
        .residue_ok (residueOk)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fcsPend <= 1'b0;
            fcsErr  <= 1'b0;
        end else begin
            fcsPend <= closeFlag & ~residueOk;
            fcsErr  <= fcsPend;
        end
    end

    assign rxIf.Rx_FCSerr = fcsErr;
`else
    assign rxIf.Rx_FCSerr = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_deframer
// Drives HDLC bit streams into hdlc_rx_deframer; a transmit-side model pushes
// expected flag/abort/byte/frame events (with their cycle) into queues, and a
// negedge monitor pops and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hdlc_rx_deframer;

    logic Clk = 1'b0;
    logic Rst;
    int   cyc = 0;

    hdlc_rx_deframer_if rxIf ();

    hdlc_rx_deframer dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .rxIf (rxIf)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic a; logic b; } ev_t;
    typedef struct { int cyc; logic [7:0] d; } byteEv_t;

    ev_t     flagQ[$];
    ev_t     abortQ[$];
    ev_t     vfQ[$];
    ev_t     eofQ[$];
    byteEv_t byteQ[$];

    int   checks   = 0;
    int   failures = 0;
    logic monOn    = 1'b0;
    logic prevVf   = 1'b0;

    // transmit-side model state
    logic        inFrame = 1'b0;
    int          bitPos  = 0;
    int          nBytes  = 0;
    logic [7:0]  mSh     = 8'h00;
    logic [15:0] mCrc    = 16'h0000;
    int          txOnes  = 0;
    int          lastN   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // drive one raw line bit; lastN is the edge that samples it
    task automatic sendBit(input logic b);
        @(negedge Clk);
        rxIf.Rx = b;
        lastN = cyc + 1;
    endtask

    task automatic sendData(input logic b);
        logic fb;
        sendBit(b);
        if (inFrame) begin
            mSh  = {b, mSh[7:1]};
            fb   = mCrc[15] ^ b;
            mCrc = {mCrc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            bitPos++;
            if (bitPos == 8) begin
                byteQ.push_back('{lastN + 8, mSh});
                bitPos = 0;
                nBytes++;
            end
        end
        if (b) begin
            txOnes++;
            if (txOnes == 5) begin
                sendBit(1'b0);
                txOnes = 0;
            end
        end else begin
            txOnes = 0;
        end
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) sendData(v[i]);
    endtask

    task automatic sendFlag();
        logic [7:0] f;
        logic       fcsExp;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) sendBit(f[i]);
        txOnes = 0;
        flagQ.push_back('{lastN + 1, 1'b0, 1'b0});
        if (!inFrame) begin
            inFrame = 1'b1;
            bitPos  = 0;
            nBytes  = 0;
            mCrc    = 16'h0000;
            vfQ.push_back('{lastN + 2, 1'b1, 1'b0});
        end else if (bitPos != 0 || nBytes != 0) begin
`ifdef HDLC_RX_FCS_EN
            fcsExp = (mCrc != 16'h0000);
`else
            fcsExp = 1'b0;
`endif
            inFrame = 1'b0;
            vfQ.push_back('{lastN + 2, 1'b0, 1'b0});
            eofQ.push_back('{lastN + 3, (bitPos != 0), fcsExp});
        end
    endtask

    task automatic sendAbort();
        logic [7:0] f;
        f = 8'hFE;
        for (int i = 0; i < 8; i++) sendBit(f[i]);
        txOnes = 0;
        abortQ.push_back('{lastN + 1, inFrame, 1'b0});
        if (inFrame) begin
            inFrame = 1'b0;
            vfQ.push_back('{lastN + 2, 1'b0, 1'b0});
            eofQ.push_back('{lastN + 3, 1'b0, 1'b0});
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0);
        txOnes = 0;
    endtask

    // one cycle of RxEN low; bytes still inside the window are lost
    task automatic dropEnable();
        int m;
        @(negedge Clk);
        rxIf.RxEN = 1'b0;
        m = cyc + 1;
        if (inFrame) begin
            inFrame = 1'b0;
            vfQ.push_back('{m, 1'b0, 1'b0});
            eofQ.push_back('{m + 1, 1'b1, 1'b0});
        end
        while (byteQ.size() > 0 && byteQ[$].cyc >= m) void'(byteQ.pop_back());
        @(negedge Clk);
        rxIf.RxEN = 1'b1;
    endtask

    always @(negedge Clk) begin : monitor
        ev_t     e;
        byteEv_t be;
        if (monOn) begin
            if (rxIf.Rx_FlagDetect) begin
                if (flagQ.size() == 0) chk("flag_unexpected", 1, 0);
                else begin
                    e = flagQ.pop_front();
                    chk("flag_cycle", cyc, e.cyc);
                end
            end
            if (rxIf.Rx_AbortDetect) begin
                if (abortQ.size() == 0) chk("abort_unexpected", 1, 0);
                else begin
                    e = abortQ.pop_front();
                    chk("abort_cycle", cyc, e.cyc);
                    chk("abort_vf", rxIf.Rx_ValidFrame, e.a);
                end
            end
            if (rxIf.Rx_ValidFrame !== prevVf) begin
                if (vfQ.size() == 0) chk("vf_unexpected", rxIf.Rx_ValidFrame, prevVf);
                else begin
                    e = vfQ.pop_front();
                    chk("vf_cycle", cyc, e.cyc);
                    chk("vf_level", rxIf.Rx_ValidFrame, e.a);
                end
            end
            prevVf = rxIf.Rx_ValidFrame;
            if (rxIf.Rx_NewByte) begin
                if (byteQ.size() == 0) chk("nb_unexpected", 1, 0);
                else begin
                    be = byteQ.pop_front();
                    chk("nb_cycle", cyc, be.cyc);
                    chk("nb_data", rxIf.Rx_Data, be.d);
                end
                chk("nb_eof_overlap", rxIf.Rx_EoF, 0);
            end
            if (rxIf.Rx_EoF) begin
                if (eofQ.size() == 0) chk("eof_unexpected", 1, 0);
                else begin
                    e = eofQ.pop_front();
                    chk("eof_cycle", cyc, e.cyc);
                    chk("eof_frame_err", rxIf.Rx_FrameError, e.a);
                    chk("eof_fcs_err", rxIf.Rx_FCSerr, e.b);
                end
            end else begin
                if (rxIf.Rx_FrameError) chk("frame_err_stray", 1, 0);
                if (rxIf.Rx_FCSerr)     chk("fcs_err_stray", 1, 0);
            end
        end
    end

    initial begin
        Rst       = 1'b0;
        rxIf.Rx   = 1'b1;
        rxIf.RxEN = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_flag",   rxIf.Rx_FlagDetect, 0);
        chk("rst_abort",  rxIf.Rx_AbortDetect, 0);
        chk("rst_vf",     rxIf.Rx_ValidFrame, 0);
        chk("rst_nb",     rxIf.Rx_NewByte, 0);
        chk("rst_data",   rxIf.Rx_Data, 8'h00);
        chk("rst_eof",    rxIf.Rx_EoF, 0);
        chk("rst_ferr",   rxIf.Rx_FrameError, 0);
        chk("rst_fcserr", rxIf.Rx_FCSerr, 0);
        Rst       = 1'b1;
        rxIf.RxEN = 1'b1;
        prevVf    = 1'b0;
        monOn     = 1'b1;

        // idle line
        for (int i = 0; i < 64; i++) sendBit(1'b1);
        chk("idle_vf", rxIf.Rx_ValidFrame, 0);
        gap(8);

        // stuffed frame: 0xFF carries an inserted zero
        sendFlag();
        sendByte(8'hFF);
        sendFlag();
        gap(12);

        // FCS: all-zero frame has zero residue; a corrupted byte does not
        sendFlag();
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        sendFlag();
        gap(12);
        sendFlag();
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h01); sendByte(8'h00);
        sendFlag();
        gap(12);

        // abort inside a frame
        sendFlag();
        sendByte(8'hA5);
        sendAbort();
        gap(12);

        // misaligned close: 12 data bits
        sendFlag();
        sendByte(8'h5A);
        sendData(1'b0); sendData(1'b1); sendData(1'b0); sendData(1'b1);
        sendFlag();
        gap(12);

        // repeated flags, then enable loss mid-byte
        sendFlag(); sendFlag(); sendFlag();
        sendByte(8'h3C);
        sendByte(8'h55);
        sendData(1'b0); sendData(1'b0); sendData(1'b1); sendData(1'b1);
        dropEnable();
        gap(20);

        chk("flagq_left",  flagQ.size(), 0);
        chk("abortq_left", abortQ.size(), 0);
        chk("vfq_left",    vfQ.size(), 0);
        chk("eofq_left",   eofQ.size(), 0);
        chk("byteq_left",  byteQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
